dev_reshuffler_seq: RTL and testbench
=====================================

Name: dev_reshuffler_seq

Overview:
- CSR-programmed job sequencer for the dev reshuffler. It gates the accelerator-side valid/ready handshakes so that exactly BEATS input beats enter and BEATS output beats leave per job.
- Latches the transpose enable at job start and exposes status and beat counters over the standard CSR request/response port.
- Sits between the streamer handshake and the reshuffler. Control only: data never passes through this block.

Parameters:
- RegCount, 8, number of CSR words.
- RegDataWidth, 32, CSR data width.
- RegAddrWidth, $clog2(RegCount), CSR address width.
- CntWidth, 16, beat counter width; BEATS is truncated to this width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- csr_addr_i  in  RegAddrWidth  CSR word address.
- csr_wr_data_i  in  RegDataWidth  write data.
- csr_wr_en_i  in  1  1=write, 0=read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request ready.
- csr_rd_data_o  out  RegDataWidth  read data.
- csr_rsp_valid_o  out  1  read response valid.
- csr_rsp_ready_i  in  1  read response ready.
- s_valid_i  in  1  upstream input valid.
- s_ready_o  out  1  upstream input ready.
- rs_a_valid_o  out  1  reshuffler a_valid.
- rs_a_ready_i  in  1  reshuffler a_ready.
- rs_z_valid_i  in  1  reshuffler z_valid.
- rs_z_ready_o  out  1  reshuffler z_ready.
- m_valid_o  out  1  downstream output valid.
- m_ready_i  in  1  downstream output ready.
- csr_en_transpose_o  out  1  transpose enable to reshuffler.
- done_o  out  1  one-cycle job-complete pulse.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values: all outputs 0, except csr_req_ready_o=1. FSM=IDLE. Counters, BEATS and TRANSPOSE are 0.
- CSR map:
  - 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 TRANSPOSE.
  - 1 BEATS (R/W).
  - 2 STATUS (RO): bit0 busy, bit1 done_sticky.
  - 3 IN_CNT (RO).
  - 4 OUT_CNT (RO).
  - 5 PERF (RO).
  - 6–7 read as 0.
- CSR writes:
  - Take effect the cycle after the req handshake. No response is generated.
  - Writes to RO addresses are ignored.
  - Writes to CTRL or BEATS while busy are ignored, including START.
- CSR reads:
  - rd_data is registered. rsp_valid rises the cycle after the req handshake and holds, with stable data, until rsp_ready.
  - csr_req_ready_o=0 while an unaccepted response is pending.
  - Back-to-back reads are allowed when rsp_ready=1.
- FSM states:
  - IDLE: START with BEATS!=0 → RUN. On entry to RUN, clear IN_CNT, OUT_CNT and done_sticky, and latch TRANSPOSE into csr_en_transpose_o. START with BEATS==0 → DONE directly.
  - RUN: rs_a_valid_o=s_valid_i and s_ready_o=rs_a_ready_i while IN_CNT<BEATS. rs_z_ready_o=m_ready_i and m_valid_o=rs_z_valid_i while OUT_CNT<BEATS. Each counter increments on its own handshake. When both counters equal BEATS → DONE.
  - DONE: done_o=1 for one cycle; set done_sticky; → IDLE.
- Gating when not in RUN, or when the matching counter has reached BEATS:
  - Input gated: s_ready_o=0, rs_a_valid_o=0.
  - Output gated: m_valid_o=0, rs_z_ready_o=0.
- Simultaneous events: input and output handshakes in the same cycle both count.
- busy=1 in RUN and DONE.
- csr_en_transpose_o holds its latched value until the next START.
- Counters never wrap: they saturate at BEATS by construction.
- Reset mid-job aborts immediately with no done_o pulse.

Optional Feature:
- Macro: DEV_RESHUFFLER_SEQ_PERF_EN.
- Defined: PERF is a 32-bit saturating counter of cycles spent in RUN. It is cleared at START.
- Undefined: no counter logic; PERF reads 0.

Decomposition:
- Package dev_reshuffler_seq_pkg holds:
  - the CSR address localparams (CTRL, BEATS, STATUS, IN_CNT, OUT_CNT, PERF);
  - the CTRL bit indices;
  - the FSM state enum (IDLE, RUN, DONE).
- One sub-module, dev_reshuffler_seq_csr_if: CSR request/response handshake and registered read mux.

Test Plan:
- Reset with s_valid_i=1, m_ready_i=1 → s_ready_o=0, m_valid_o=0, csr_req_ready_o=1, done_o=0.
- Write BEATS=4 and CTRL=0b11, with a/z always valid/ready → exactly 4 input and 4 output handshakes. done_o pulses once, the cycle after the 4th output. csr_en_transpose_o=1. STATUS reads 0b10.
- BEATS=3 with random stalls on rs_a_ready_i and m_ready_i → IN_CNT and OUT_CNT each read 3. No handshake occurs beyond the 3rd on either side.
- START with BEATS=0 → done_o pulses 1 cycle after the write. No stream handshakes occur.
- During a job, write BEATS=9 and CTRL.TRANSPOSE=0 → ignored: the job completes at the original count and transpose stays 1.
- Read with rsp_ready_i held 0 for 5 cycles → rsp_valid and data stay stable and req_ready=0 throughout. With PERF_EN, PERF equals the RUN cycle count.

Source files
------------

// File: rtl/dev_reshuffler_seq_pkg.sv
// rtl/dev_reshuffler_seq_pkg.sv - shared CSR map, CTRL bit indices and FSM state type
// Contents: CSR word addresses, CTRL field bit positions, sequencer state enum.
package dev_reshuffler_seq_pkg;

   localparam int unsigned ADDR_CTRL    = 0;
   localparam int unsigned ADDR_BEATS   = 1;
   localparam int unsigned ADDR_STATUS  = 2;
   localparam int unsigned ADDR_IN_CNT  = 3;
   localparam int unsigned ADDR_OUT_CNT = 4;
   localparam int unsigned ADDR_PERF    = 5;

   localparam int unsigned CTRL_START_BIT     = 0;
   localparam int unsigned CTRL_TRANSPOSE_BIT = 1;

   localparam int unsigned STATUS_BUSY_BIT = 0;
   localparam int unsigned STATUS_DONE_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/dev_reshuffler_seq_csr_if.sv
// rtl/dev_reshuffler_seq_csr_if.sv - CSR request/response handshake with registered read mux
// Ports: csr_* request/response channel from the host side; rd_words_i is the flat
// register file view supplied by the owner; wr_o/wr_addr_o/wr_data_o is a one-cycle
// write strobe issued on an accepted write request.
module dev_reshuffler_seq_csr_if #(
   parameter int unsigned RegCount     = 8,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned RegAddrWidth = $clog2(RegCount)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [RegAddrWidth-1:0]                csr_addr_i,
   input  logic [RegDataWidth-1:0]                csr_wr_data_i,
   input  logic                                   csr_wr_en_i,
   input  logic                                   csr_req_valid_i,
   output logic                                   csr_req_ready_o,
   output logic [RegDataWidth-1:0]                csr_rd_data_o,
   output logic                                   csr_rsp_valid_o,
   input  logic                                   csr_rsp_ready_i,
   input  logic [RegCount-1:0][RegDataWidth-1:0]  rd_words_i,
   output logic                                   wr_o,
   output logic [RegAddrWidth-1:0]                wr_addr_o,
   output logic [RegDataWidth-1:0]                wr_data_o
);

   logic                    rsp_valid_q, rsp_valid_d;
   logic [RegDataWidth-1:0] rd_data_q, rd_data_d;
   logic                    req_hs;
   logic                    rd_hs;

   // A new request may be taken in the same cycle the pending response drains.
   assign csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
   assign req_hs          = csr_req_valid_i && csr_req_ready_o;
   assign rd_hs           = req_hs && !csr_wr_en_i;

   assign wr_o      = req_hs && csr_wr_en_i;
   assign wr_addr_o = csr_addr_i;
   assign wr_data_o = csr_wr_data_i;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rd_data_d   = rd_data_q;
      if (rd_hs) begin
         rsp_valid_d = 1'b1;
         rd_data_d   = rd_words_i[csr_addr_i];
      end else if (csr_rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign csr_rsp_valid_o = rsp_valid_q;
   assign csr_rd_data_o   = rd_data_q;

endmodule

// File: rtl/dev_reshuffler_seq.sv
// rtl/dev_reshuffler_seq.sv - CSR-programmed job sequencer gating reshuffler handshakes
// Ports: csr_* register port; s_valid_i/s_ready_o upstream input handshake;
// rs_a_valid_o/rs_a_ready_i and rs_z_valid_i/rs_z_ready_o reshuffler sides;
// m_valid_o/m_ready_i downstream output handshake; csr_en_transpose_o latched
// transpose enable; done_o one-cycle job-complete pulse.
// Optional feature: DEV_RESHUFFLER_SEQ_PERF_EN adds a saturating RUN-cycle counter (PERF).
module dev_reshuffler_seq
   import dev_reshuffler_seq_pkg::*;
#(
   parameter int unsigned RegCount     = 8,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned RegAddrWidth = $clog2(RegCount),
   parameter int unsigned CntWidth     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [RegAddrWidth-1:0] csr_addr_i,
   input  logic [RegDataWidth-1:0] csr_wr_data_i,
   input  logic                    csr_wr_en_i,
   input  logic                    csr_req_valid_i,
   output logic                    csr_req_ready_o,
   output logic [RegDataWidth-1:0] csr_rd_data_o,
   output logic                    csr_rsp_valid_o,
   input  logic                    csr_rsp_ready_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   output logic                    rs_a_valid_o,
   input  logic                    rs_a_ready_i,
   input  logic                    rs_z_valid_i,
   output logic                    rs_z_ready_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic                    csr_en_transpose_o,
   output logic                    done_o
);

   state_e                  state_q, state_d;
   logic [CntWidth-1:0]     beats_q, beats_d;
   logic [CntWidth-1:0]     in_cnt_q, in_cnt_d;
   logic [CntWidth-1:0]     out_cnt_q, out_cnt_d;
   logic                    transpose_q, transpose_d;
   logic                    en_tr_q, en_tr_d;
   logic                    done_sticky_q, done_sticky_d;
   logic [31:0]             perf_value;

   logic                    wr;
   logic [RegAddrWidth-1:0] wr_addr;
   logic [RegDataWidth-1:0] wr_data;
   logic [RegCount-1:0][RegDataWidth-1:0] rd_words;

   logic idle, ctrl_wr, beats_wr, start, run_entry;
   logic in_open, out_open, in_hs, out_hs;
   logic unused_wr_data;

   dev_reshuffler_seq_csr_if #(
      .RegCount     (RegCount),
      .RegDataWidth (RegDataWidth),
      .RegAddrWidth (RegAddrWidth)
   ) u_csr_if (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .csr_addr_i      (csr_addr_i),
      .csr_wr_data_i   (csr_wr_data_i),
      .csr_wr_en_i     (csr_wr_en_i),
      .csr_req_valid_i (csr_req_valid_i),
      .csr_req_ready_o (csr_req_ready_o),
      .csr_rd_data_o   (csr_rd_data_o),
      .csr_rsp_valid_o (csr_rsp_valid_o),
      .csr_rsp_ready_i (csr_rsp_ready_i),
      .rd_words_i      (rd_words),
      .wr_o            (wr),
      .wr_addr_o       (wr_addr),
      .wr_data_o       (wr_data)
   );

   assign unused_wr_data = ^wr_data;

   // CTRL and BEATS are writable only while idle; START is part of the CTRL write.
   assign idle      = (state_q == ST_IDLE);
   assign ctrl_wr   = wr && idle && (wr_addr == RegAddrWidth'(ADDR_CTRL));
   assign beats_wr  = wr && idle && (wr_addr == RegAddrWidth'(ADDR_BEATS));
   assign start     = ctrl_wr && wr_data[CTRL_START_BIT];
   assign run_entry = start && (beats_q != '0);

   assign in_open  = (state_q == ST_RUN) && (in_cnt_q < beats_q);
   assign out_open = (state_q == ST_RUN) && (out_cnt_q < beats_q);
   assign in_hs    = in_open && s_valid_i && rs_a_ready_i;
   assign out_hs   = out_open && rs_z_valid_i && m_ready_i;

   always_comb begin
      beats_d       = beats_q;
      transpose_d   = transpose_q;
      en_tr_d       = en_tr_q;
      in_cnt_d      = in_cnt_q;
      out_cnt_d     = out_cnt_q;
      done_sticky_d = done_sticky_q;
      if (beats_wr)
         beats_d = wr_data[CntWidth-1:0];
      if (ctrl_wr)
         transpose_d = wr_data[CTRL_TRANSPOSE_BIT];
      if (run_entry) begin
         en_tr_d       = wr_data[CTRL_TRANSPOSE_BIT];
         in_cnt_d      = '0;
         out_cnt_d     = '0;
         done_sticky_d = 1'b0;
      end else begin
         if (in_hs)
            in_cnt_d = in_cnt_q + 1'b1;
         if (out_hs)
            out_cnt_d = out_cnt_q + 1'b1;
      end
      if (state_q == ST_DONE)
         done_sticky_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beats_q       <= '0;
         transpose_q   <= 1'b0;
         en_tr_q       <= 1'b0;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         done_sticky_q <= 1'b0;
      end else begin
         beats_q       <= beats_d;
         transpose_q   <= transpose_d;
         en_tr_q       <= en_tr_d;
         in_cnt_q      <= in_cnt_d;
         out_cnt_q     <= out_cnt_d;
         done_sticky_q <= done_sticky_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Completion looks at next counter values so DONE follows the final beat directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (beats_q == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if ((in_cnt_d == beats_q) && (out_cnt_d == beats_q)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rs_a_valid_o       = in_open && s_valid_i;
      s_ready_o          = in_open && rs_a_ready_i;
      m_valid_o          = out_open && rs_z_valid_i;
      rs_z_ready_o       = out_open && m_ready_i;
      done_o             = (state_q == ST_DONE);
      csr_en_transpose_o = en_tr_q;
   end

`ifdef DEV_RESHUFFLER_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (start)
         perf_d = '0;
      else if ((state_q == ST_RUN) && (perf_q != '1))
         perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         perf_q <= '0;
      else
         perf_q <= perf_d;
   end

   assign perf_value = perf_q;
`else
   assign perf_value = '0;
`endif

   always_comb begin
      rd_words = '0;
      rd_words[ADDR_CTRL][CTRL_TRANSPOSE_BIT]   = transpose_q;
      rd_words[ADDR_BEATS]                      = RegDataWidth'(beats_q);
      rd_words[ADDR_STATUS][STATUS_BUSY_BIT]    = (state_q != ST_IDLE);
      rd_words[ADDR_STATUS][STATUS_DONE_BIT]    = done_sticky_q;
      rd_words[ADDR_IN_CNT]                     = RegDataWidth'(in_cnt_q);
      rd_words[ADDR_OUT_CNT]                    = RegDataWidth'(out_cnt_q);
      rd_words[ADDR_PERF]                       = RegDataWidth'(perf_value);
   end

endmodule

// File: tb/tb_dev_reshuffler_seq.sv
// tb/tb_dev_reshuffler_seq.sv - directed self-checking bench for dev_reshuffler_seq
module tb_dev_reshuffler_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  csr_addr;
   logic [31:0] csr_wr_data;
   logic        csr_wr_en;
   logic        csr_req_valid;
   logic        csr_req_ready;
   logic [31:0] csr_rd_data;
   logic        csr_rsp_valid;
   logic        csr_rsp_ready;
   logic        s_valid, s_ready, rs_a_valid, rs_a_ready;
   logic        rs_z_valid, rs_z_ready, m_valid, m_ready;
   logic        en_transpose, done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int in_tot   = 0;
   int out_tot  = 0;
   int done_tot = 0;
   int last_out_cyc = 0;
   int done_cyc     = 0;
   int last_wr_cyc  = 0;

   dev_reshuffler_seq dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .csr_addr_i         (csr_addr),
      .csr_wr_data_i      (csr_wr_data),
      .csr_wr_en_i        (csr_wr_en),
      .csr_req_valid_i    (csr_req_valid),
      .csr_req_ready_o    (csr_req_ready),
      .csr_rd_data_o      (csr_rd_data),
      .csr_rsp_valid_o    (csr_rsp_valid),
      .csr_rsp_ready_i    (csr_rsp_ready),
      .s_valid_i          (s_valid),
      .s_ready_o          (s_ready),
      .rs_a_valid_o       (rs_a_valid),
      .rs_a_ready_i       (rs_a_ready),
      .rs_z_valid_i       (rs_z_valid),
      .rs_z_ready_o       (rs_z_ready),
      .m_valid_o          (m_valid),
      .m_ready_i          (m_ready),
      .csr_en_transpose_o (en_transpose),
      .done_o             (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (s_valid && s_ready) in_tot++;
      if (m_valid && m_ready) begin
         out_tot++;
         last_out_cyc = cyc;
      end
      if (done) begin
         done_tot++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [2:0] addr, input logic [31:0] data);
      csr_addr      = addr;
      csr_wr_data   = data;
      csr_wr_en     = 1'b1;
      csr_req_valid = 1'b1;
      tick();
      last_wr_cyc   = cyc;
      csr_req_valid = 1'b0;
      csr_wr_en     = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] addr, output logic [31:0] data);
      int n = 0;
      csr_addr      = addr;
      csr_wr_en     = 1'b0;
      csr_rsp_ready = 1'b1;
      csr_req_valid = 1'b1;
      tick();
      csr_req_valid = 1'b0;
      while (!csr_rsp_valid && n < 8) begin
         tick();
         n++;
      end
      if (!csr_rsp_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL csr_read_timeout addr=%0d rsp_valid=%0b required 1", addr, csr_rsp_valid);
      end
      data = csr_rd_data;
      tick();
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_tot == d0 && n < 200) begin
         tick();
         n++;
      end
      n_checks++;
      if (done_tot == d0) begin
         n_fail++;
         $display("FAIL wait_done_timeout done_count=%0d required >%0d", done_tot, d0);
      end
      repeat (4) tick();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1; rs_a_ready = 1'b1; rs_z_valid = 1'b1;
      csr_req_valid = 1'b0; csr_wr_en = 1'b0; csr_addr = '0; csr_wr_data = '0; csr_rsp_ready = 1'b1;
      #1;
      repeat (2) tick();
      n_checks += 6;
      if (s_ready !== 1'b0)      begin n_fail++; $display("FAIL reset_s_ready got %0b required 0", s_ready); end
      if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_m_valid got %0b required 0", m_valid); end
      if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b required 1", csr_req_ready); end
      if (done !== 1'b0)         begin n_fail++; $display("FAIL reset_done got %0b required 0", done); end
      if (rs_a_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_a_valid got %0b required 0", rs_a_valid); end
      if (en_transpose !== 1'b0) begin n_fail++; $display("FAIL reset_transpose got %0b required 0", en_transpose); end
      rst_n = 1'b1;
      tick();
      csr_read(3'd1, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_beats got %0d required 0", d); end
      csr_read(3'd2, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status got %0d required 0", d); end
   endtask

   task automatic test_basic();
      int i0, o0, d0;
      logic [31:0] d;
      s_valid = 1'b1; rs_a_ready = 1'b1; rs_z_valid = 1'b1; m_ready = 1'b1;
      i0 = in_tot; o0 = out_tot; d0 = done_tot;
      csr_write(3'd1, 32'd4);
      csr_write(3'd0, 32'd3);
      wait_done(d0);
      n_checks += 4;
      if (in_tot - i0 !== 4)  begin n_fail++; $display("FAIL basic_in_hs got %0d required 4", in_tot - i0); end
      if (out_tot - o0 !== 4) begin n_fail++; $display("FAIL basic_out_hs got %0d required 4", out_tot - o0); end
      if (done_tot - d0 !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d required 1", done_tot - d0); end
      if (done_cyc !== last_out_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing got cycle %0d required %0d", done_cyc, last_out_cyc + 1); end
      n_checks++;
      if (en_transpose !== 1'b1) begin n_fail++; $display("FAIL basic_transpose got %0b required 1", en_transpose); end
      csr_read(3'd2, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL basic_status got %0h required 2", d); end
      csr_read(3'd0, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL basic_ctrl_read got %0h required 2", d); end
      csr_read(3'd5, d);
      n_checks++;
`ifdef DEV_RESHUFFLER_SEQ_PERF_EN
      if (d !== 32'd4) begin n_fail++; $display("FAIL basic_perf got %0d required 4", d); end
`else
      if (d !== 32'd0) begin n_fail++; $display("FAIL basic_perf got %0d required 0", d); end
`endif
      csr_read(3'd6, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL basic_unmapped got %0h required 0", d); end
   endtask

   task automatic test_stall();
      int i0, o0, d0;
      logic [31:0] d;
      logic [39:0] pa;
      logic [39:0] pm;
      pa = 40'h5A5A5A5A5A;
      pm = 40'h3C3C3C3C3C;
      s_valid = 1'b1; rs_z_valid = 1'b1; rs_a_ready = 1'b0; m_ready = 1'b0;
      i0 = in_tot; o0 = out_tot; d0 = done_tot;
      csr_write(3'd1, 32'd3);
      csr_write(3'd0, 32'd1);
      for (int i = 0; i < 40; i++) begin
         rs_a_ready = pa[i];
         m_ready    = pm[i];
         tick();
      end
      rs_a_ready = 1'b1; m_ready = 1'b1;
      repeat (3) tick();
      n_checks += 4;
      if (in_tot - i0 !== 3)  begin n_fail++; $display("FAIL stall_in_hs got %0d required 3", in_tot - i0); end
      if (out_tot - o0 !== 3) begin n_fail++; $display("FAIL stall_out_hs got %0d required 3", out_tot - o0); end
      if (done_tot - d0 !== 1) begin n_fail++; $display("FAIL stall_done_pulses got %0d required 1", done_tot - d0); end
      if (en_transpose !== 1'b0) begin n_fail++; $display("FAIL stall_transpose got %0b required 0", en_transpose); end
      csr_read(3'd3, d);
      n_checks++;
      if (d !== 32'd3) begin n_fail++; $display("FAIL stall_in_cnt got %0d required 3", d); end
      csr_read(3'd4, d);
      n_checks++;
      if (d !== 32'd3) begin n_fail++; $display("FAIL stall_out_cnt got %0d required 3", d); end
   endtask

   task automatic test_zero_beats();
      int i0, o0, d0, w;
      s_valid = 1'b1; rs_a_ready = 1'b1; rs_z_valid = 1'b1; m_ready = 1'b1;
      csr_write(3'd1, 32'd0);
      i0 = in_tot; o0 = out_tot; d0 = done_tot;
      csr_write(3'd0, 32'd1);
      w = last_wr_cyc;
      repeat (4) tick();
      n_checks += 4;
      if (done_tot - d0 !== 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d required 1", done_tot - d0); end
      if (done_cyc !== w)      begin n_fail++; $display("FAIL zero_done_timing got cycle %0d required %0d", done_cyc, w); end
      if (in_tot - i0 !== 0)   begin n_fail++; $display("FAIL zero_in_hs got %0d required 0", in_tot - i0); end
      if (out_tot - o0 !== 0)  begin n_fail++; $display("FAIL zero_out_hs got %0d required 0", out_tot - o0); end
   endtask

   task automatic test_busy_writes();
      int i0, o0, d0;
      logic [31:0] d;
      s_valid = 1'b0; rs_z_valid = 1'b0; rs_a_ready = 1'b1; m_ready = 1'b1;
      i0 = in_tot; o0 = out_tot; d0 = done_tot;
      csr_write(3'd1, 32'd4);
      csr_write(3'd0, 32'd3);
      csr_write(3'd1, 32'd9);
      csr_write(3'd0, 32'd1);
      csr_read(3'd2, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL busy_status got %0h required 1", d); end
      csr_read(3'd1, d);
      n_checks++;
      if (d !== 32'd4) begin n_fail++; $display("FAIL busy_beats got %0d required 4", d); end
      s_valid = 1'b1; rs_z_valid = 1'b1;
      wait_done(d0);
      n_checks += 3;
      if (in_tot - i0 !== 4)  begin n_fail++; $display("FAIL busy_in_hs got %0d required 4", in_tot - i0); end
      if (out_tot - o0 !== 4) begin n_fail++; $display("FAIL busy_out_hs got %0d required 4", out_tot - o0); end
      if (en_transpose !== 1'b1) begin n_fail++; $display("FAIL busy_transpose got %0b required 1", en_transpose); end
      csr_read(3'd0, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL busy_ctrl_read got %0h required 2", d); end
   endtask

   task automatic test_read_stall();
      csr_addr      = 3'd1;
      csr_wr_en     = 1'b0;
      csr_rsp_ready = 1'b0;
      csr_req_valid = 1'b1;
      tick();
      csr_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks += 3;
         if (csr_rsp_valid !== 1'b1)  begin n_fail++; $display("FAIL stall_rsp_valid[%0d] got %0b required 1", i, csr_rsp_valid); end
         if (csr_rd_data !== 32'd4)   begin n_fail++; $display("FAIL stall_rd_data[%0d] got %0d required 4", i, csr_rd_data); end
         if (csr_req_ready !== 1'b0)  begin n_fail++; $display("FAIL stall_req_ready[%0d] got %0b required 0", i, csr_req_ready); end
         tick();
      end
      csr_rsp_ready = 1'b1;
      tick();
      n_checks += 2;
      if (csr_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rsp_valid got %0b required 0", csr_rsp_valid); end
      if (csr_req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_req_ready got %0b required 1", csr_req_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_beats();
      test_busy_writes();
      test_read_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
